// File: rtl/rv_decode_stage_if.sv
// +------------------------------------------------------------------+
// | rv_decode_stage_if                                               |
// | Instruction, decoded-bundle and writeback bundle for the decode  |
// | stage.                                                           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface rv_decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_a;
  logic [XLEN-1:0]     out_b;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [4:0]          out_rd;
  logic                out_illegal;
  logic                wb_en;
  logic [4:0]          wb_rd;
  logic [XLEN-1:0]     wb_data;

  // Upstream fetch + downstream ALU + writeback source, seen as one driver.
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/rv_decode_stage.sv
// +------------------------------------------------------------------+
// | rv_decode_stage                                                  |
// | RV32I OP/OP-IMM decode + register-file operand fetch into a      |
// | single registered ALU bundle. Option macro: WB_BYPASS_EN.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  rv_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9);

  function automatic logic [ALU_OP_W-1:0] f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];

  // Register file; entry 0 is never written so it always reads zero.
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      regs_d[bus.wb_rd] = bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Operand read
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
`ifdef WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1)) begin
      rs1_val = bus.wb_data;
    end
    if (bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2)) begin
      rs2_val = bus.wb_data;
    end
`endif
  end

  // Decode
  logic                dec_illegal;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_use_imm;
  logic                dec_use_shamt;

  always_comb begin
    dec_illegal   = 1'b0;
    dec_op        = ALU_ADD;
    dec_use_imm   = 1'b0;
    dec_use_shamt = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_op = f3_to_op(funct3);
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
          dec_op = ALU_SUB;
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
          dec_op = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        case (funct3)
          3'b001: begin
            dec_use_shamt = 1'b1;
            dec_op        = ALU_SLL;
            dec_illegal   = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec_use_shamt = 1'b1;
            if (funct7 == F7_BASE) begin
              dec_op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_op = ALU_SRA;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_op = f3_to_op(funct3);
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Assemble the bundle; illegal words collapse to a harmless ADD 0,0 -> x0.
  logic [XLEN-1:0]     bnd_a;
  logic [XLEN-1:0]     bnd_b;
  logic [ALU_OP_W-1:0] bnd_op;
  logic [4:0]          bnd_rd;

  always_comb begin
    bnd_a  = rs1_val;
    bnd_op = dec_op;
    bnd_rd = rd;
    if (dec_use_shamt) begin
      bnd_b = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
    end else if (dec_use_imm) begin
      bnd_b = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    end else begin
      bnd_b = rs2_val;
    end
    if (dec_illegal) begin
      bnd_a  = '0;
      bnd_b  = '0;
      bnd_op = ALU_ADD;
      bnd_rd = 5'd0;
    end
  end

  // Output register and handshake
  logic                out_valid_q,   out_valid_d;
  logic [XLEN-1:0]     out_a_q,       out_a_d;
  logic [XLEN-1:0]     out_b_q,       out_b_d;
  logic [ALU_OP_W-1:0] out_alu_op_q,  out_alu_op_d;
  logic [4:0]          out_rd_q,      out_rd_d;
  logic                out_illegal_q, out_illegal_d;
  logic                in_ready;
  logic                accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_alu_op_d  = out_alu_op_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = bnd_a;
      out_b_d       = bnd_b;
      out_alu_op_d  = bnd_op;
      out_rd_d      = bnd_rd;
      out_illegal_d = dec_illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_alu_op_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_alu_op_q  <= out_alu_op_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_b       = out_b_q;
  assign bus.out_alu_op  = out_alu_op_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

`default_nettype wire
